// File: rtl/alu_pipe_param_pkg.sv
// alu_pkg: shared definitions for the handshaked, parametrised ALU.
//   - Opcode constants. These keep the 5-bit map of the original combinational ALU.
//   - The FSM state type and the shift/rotate kind type.
//   - Bit positions of {Z,N,C,V} inside the flags vector.
//   - A helper that recognises the shift/rotate opcode group.
// Optional feature macro: ALU_FLAGS_EN. The flag index constants are only used when it is defined.
package alu_pkg;

  localparam logic [4:0] OC_ADD  = 5'b10100;
  localparam logic [4:0] OC_SUB  = 5'b10110;
  localparam logic [4:0] OC_DEC  = 5'b10010;
  localparam logic [4:0] OC_NEG  = 5'b10001;
  localparam logic [4:0] OC_ZERO = 5'b00000;
  localparam logic [4:0] OC_A    = 5'b01010;
  localparam logic [4:0] OC_NOTA = 5'b00101;
  localparam logic [4:0] OC_AND  = 5'b01000;
  localparam logic [4:0] OC_OR   = 5'b01110;
  localparam logic [4:0] OC_XOR  = 5'b00110;
  localparam logic [4:0] OC_ONES = 5'b01111;
  localparam logic [4:0] OC_SLL  = 5'b11000;
  localparam logic [4:0] OC_SRL  = 5'b11001;
  localparam logic [4:0] OC_ROL  = 5'b11010;
  localparam logic [4:0] OC_ROR  = 5'b11011;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  // The low two opcode bits select the kind of shift or rotate.
  // Bit 0 set means the operation moves data to the right.
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_ROL = 2'b10,
    SH_ROR = 2'b11
  } shift_kind_t;

  function automatic logic is_shift(input logic [4:0] oc);
    return oc[4:2] == 3'b110;
  endfunction

endpackage

// File: rtl/alu_pipe_param_if.sv
// alu_pipe_param_if: request/response bundle of the handshaked ALU.
//   Request : in_valid, in_ready, oc, a, b, c0. A transfer happens when in_valid & in_ready.
//   Response: out_valid, out_ready, o, and flags when ALU_FLAGS_EN is defined.
//             A transfer happens when out_valid & out_ready.
//   Modports: master is the requester/consumer; slave is the ALU itself.
interface alu_pipe_param_if #(parameter int WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       oc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c0;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
`ifdef ALU_FLAGS_EN
  logic [3:0]       flags;
`endif

  modport master (
    output in_valid, oc, a, b, c0, out_ready,
    input  in_ready, out_valid, o
`ifdef ALU_FLAGS_EN
    , input flags
`endif
  );

  modport slave (
    input  in_valid, oc, a, b, c0, out_ready,
    output in_ready, out_valid, o
`ifdef ALU_FLAGS_EN
    , output flags
`endif
  );

endinterface

// File: rtl/alu_pipe_param_core_comb.sv
// alu_core_comb: purely combinational datapath of the ALU.
//   oc, a, b, c0 -> res : the single-cycle result for arithmetic, logic and reserved codes.
//                         Shift codes pass a through here; this is the n==0 result.
//   step_in, step_kind, step_fill -> step_out : one single-bit shift or rotate step.
//   With ALU_FLAGS_EN defined, three extra outputs exist:
//     res_c  : carry-out of the arithmetic operation.
//     res_v  : signed overflow of the arithmetic operation.
//     step_c : the bit the step moves out of the word.
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [4:0]       oc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic [WIDTH-1:0] res,
  input  logic [WIDTH-1:0] step_in,
  input  shift_kind_t      step_kind,
  input  logic             step_fill,
  output logic [WIDTH-1:0] step_out
`ifdef ALU_FLAGS_EN
  ,
  output logic             res_c,
  output logic             res_v,
  output logic             step_c
`endif
);

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] logic_res;
  logic             is_arith;

  assign is_arith = (oc[4:3] == 2'b10);

  // The adder operands are shaped by the opcode.
  // oc[0] inverts A.
  // oc[2:1] chooses the B-side addend: 0, all ones, B, or ~B.
  always_comb begin
    opa = oc[0] ? ~a : a;
    case (oc[2:1])
      2'b00:   opb = '0;
      2'b01:   opb = '1;
      2'b10:   opb = b;
      default: opb = ~b;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] sum;
  assign sum    = {1'b0, opa} + {1'b0, opb} + (WIDTH+1)'(c0);
  assign res_c  = is_arith & sum[WIDTH];
  assign res_v  = is_arith & (opa[WIDTH-1] == opb[WIDTH-1]) & (sum[WIDTH-1] != opa[WIDTH-1]);
  assign step_c = step_kind[0] ? step_in[0] : step_in[WIDTH-1];
`else
  logic [WIDTH-1:0] sum;
  assign sum = opa + opb + WIDTH'(c0);
`endif

  // Logic operations are decoded from the full low nibble.
  // Any code that is not listed gives zero.
  always_comb begin
    case ({1'b0, oc[3:0]})
      OC_A:    logic_res = a;
      OC_NOTA: logic_res = ~a;
      OC_AND:  logic_res = a & b;
      OC_OR:   logic_res = a | b;
      OC_XOR:  logic_res = a ^ b;
      OC_ONES: logic_res = '1;
      default: logic_res = '0;
    endcase
  end

  // Result selection by opcode group.
  // The reserved 111xx group falls through to zero.
  always_comb begin
    res = '0;
    if (is_arith) begin
      res = sum[WIDTH-1:0];
    end else if (!oc[4]) begin
      res = logic_res;
    end else if (is_shift(oc)) begin
      res = a;
    end
  end

  // One step of a shift or rotate.
  // Plain shifts bring in step_fill.
  // Rotates bring in the bit that leaves at the other end.
  always_comb begin
    case (step_kind)
      SH_SLL:  step_out = {step_in[WIDTH-2:0], step_fill};
      SH_SRL:  step_out = {step_fill, step_in[WIDTH-1:1]};
      SH_ROL:  step_out = {step_in[WIDTH-2:0], step_in[WIDTH-1]};
      default: step_out = {step_in[0], step_in[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/alu_pipe_param.sv
// alu_pipe_param: parametrised ALU with valid/ready flow control and a registered result.
//   Parameters:
//     WIDTH : operand width, at least 4.
//     SHW   : number of shift-distance bits, taken from b[SHW-1:0].
//   Ports:
//     clk : rising-edge clock.
//     rst : asynchronous active-high reset.
//     bus : alu_pipe_param_if slave modport, carrying
//           in_valid/in_ready/oc/a/b/c0 and out_valid/out_ready/o, plus flags.
//   Optional feature macro: ALU_FLAGS_EN. When defined, it adds a registered {Z,N,C,V} flags output.
//   Non-shift operations complete one cycle after accept.
//   Shifts by n run one bit per cycle and complete after n+1 cycles.
module alu_pipe_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  alu_pipe_param_if.slave   bus
);

  state_t           state;
  logic [SHW-1:0]   cnt;
  shift_kind_t      sh_kind;
  logic             sh_fill;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] step_out;
  logic [SHW-1:0]   n;
  logic             accept;
  logic             start_shift;

  assign n           = bus.b[SHW-1:0];
  assign bus.in_ready  = (state == IDLE) | ((state == HOLD) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign start_shift   = is_shift(bus.oc) && (n != '0);
  assign bus.out_valid = (state == HOLD);
  assign bus.o         = o_q;

`ifdef ALU_FLAGS_EN
  logic       res_c;
  logic       res_v;
  logic       step_c;
  logic [3:0] flags_q;
  logic [3:0] res_flags;
  logic [3:0] step_flags;

  assign bus.flags = flags_q;

  // Flags are formed for the value that o will take next: the single-cycle result or the final shift step.
  // Shifts never report overflow.
  always_comb begin
    res_flags          = '0;
    res_flags[FLAG_Z]  = (res == '0);
    res_flags[FLAG_N]  = res[WIDTH-1];
    res_flags[FLAG_C]  = res_c;
    res_flags[FLAG_V]  = res_v;
    step_flags         = '0;
    step_flags[FLAG_Z] = (step_out == '0);
    step_flags[FLAG_N] = step_out[WIDTH-1];
    step_flags[FLAG_C] = step_c;
  end
`endif

  alu_core_comb #(.WIDTH(WIDTH)) core (
    .oc        (bus.oc),
    .a         (bus.a),
    .b         (bus.b),
    .c0        (bus.c0),
    .res       (res),
    .step_in   (o_q),
    .step_kind (sh_kind),
    .step_fill (sh_fill),
    .step_out  (step_out)
`ifdef ALU_FLAGS_EN
    ,
    .res_c     (res_c),
    .res_v     (res_v),
    .step_c    (step_c)
`endif
  );

  // Control FSM and result register.
  // IDLE and HOLD share the accept path, so a result can drain on the same edge that a new
  // operation is taken.
  // In SHIFT, o_q is the running value. A count of 1 means the current step is the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      o_q     <= '0;
      cnt     <= '0;
      sh_kind <= SH_SLL;
      sh_fill <= 1'b0;
`ifdef ALU_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          o_q <= step_out;
          cnt <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state <= HOLD;
`ifdef ALU_FLAGS_EN
            flags_q <= step_flags;
`endif
          end
        end
        default: begin
          if (accept) begin
            if (start_shift) begin
              o_q     <= bus.a;
              cnt     <= n;
              sh_kind <= shift_kind_t'(bus.oc[1:0]);
              sh_fill <= bus.c0;
              state   <= SHIFT;
            end else begin
              o_q   <= res;
              state <= HOLD;
`ifdef ALU_FLAGS_EN
              flags_q <= res_flags;
`endif
            end
          end else if ((state == HOLD) && bus.out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb_alu_pipe_param: self-checking bench for alu_pipe_param.
//   It runs directed cases for add/negate/subtract, shifts and rotates, backpressure,
//   back-to-back accepts and reset during a shift.
//   It then runs randomized operations against an arithmetic reference model.
//   Build with or without ALU_FLAGS_EN. Parameter W selects the width.
module tb_alu_pipe_param;
  import alu_pkg::*;

  parameter int W = 16;
  localparam int SHW = $clog2(W);
  localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  alu_pipe_param_if #(.WIDTH(W)) bus ();

  alu_pipe_param #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench goes through this task.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model. It works on whole words with plain shifts and adds.
  // Flags are returned as {Z,N,C,V}.
  function automatic void model(input logic [4:0] oc, input logic [63:0] a, input logic [63:0] b,
                                input logic c0, output logic [63:0] res, output logic [3:0] fl);
    logic [63:0] opa, opb, sum;
    logic        c, v;
    int          n;
    res = 64'd0;
    c   = 1'b0;
    v   = 1'b0;
    n   = int'(b & ((64'd1 << SHW) - 64'd1));
    if (oc[4:3] == 2'b10) begin
      opa = oc[0] ? (~a & MASK) : a;
      opb = oc[2] ? (oc[1] ? (~b & MASK) : b) : (oc[1] ? MASK : 64'd0);
      sum = opa + opb + 64'(c0);
      res = sum & MASK;
      c   = sum[W];
      v   = (opa[W-1] == opb[W-1]) && (res[W-1] != opa[W-1]);
    end else if (!oc[4]) begin
      case (oc[3:0])
        4'b1010: res = a;
        4'b0101: res = ~a & MASK;
        4'b1000: res = a & b;
        4'b1110: res = a | b;
        4'b0110: res = a ^ b;
        4'b1111: res = MASK;
        default: res = 64'd0;
      endcase
    end else if (!oc[2]) begin
      if (n == 0) begin
        res = a;
      end else begin
        case (oc[1:0])
          2'b00: begin
            res = ((a << n) | (c0 ? ((64'd1 << n) - 64'd1) : 64'd0)) & MASK;
            c   = a[W-n];
          end
          2'b01: begin
            res = (a >> n) | (c0 ? (MASK & ~(MASK >> n)) : 64'd0);
            c   = a[n-1];
          end
          2'b10: begin
            res = ((a << n) | (a >> (W - n))) & MASK;
            c   = res[0];
          end
          default: begin
            res = ((a >> n) | (a << (W - n))) & MASK;
            c   = res[W-1];
          end
        endcase
      end
    end
    fl = {res == 64'd0, res[W-1], c, v};
  endfunction

  // Sends one operation with out_ready high.
  // Measures the latency and the in_ready-low cycles, then checks the result and flags.
  // After the accept, the inputs are scrambled because they must be ignored from then on.
  task automatic applyStimulus(input string tag, input logic [4:0] oc, input logic [63:0] a,
                               input logic [63:0] b, input logic c0, input logic [63:0] exp_o);
    logic [63:0] mo;
    logic [3:0]  mf;
    int          lat, busy, exp_lat, n;
    model(oc, a & MASK, b & MASK, c0, mo, mf);
    n       = int'(b & ((64'd1 << SHW) - 64'd1));
    exp_lat = (oc[4:2] == 3'b110 && n != 0) ? n + 1 : 1;
    @(negedge clk);
    checkOutput({tag, ".rdy"}, 64'(bus.in_ready), 64'd1);
    bus.oc       = oc;
    bus.a        = a[W-1:0];
    bus.b        = b[W-1:0];
    bus.c0       = c0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.oc       = 5'($urandom);
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.c0       = 1'($urandom);
    lat  = 1;
    busy = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid || lat > 200) break;
      if (!bus.in_ready) busy++;
      lat++;
    end
    checkOutput({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, ".busy"}, 64'(busy), 64'(exp_lat - 1));
    checkOutput({tag, ".o"}, 64'(bus.o), exp_o);
`ifdef ALU_FLAGS_EN
    checkOutput({tag, ".flags"}, 64'(bus.flags), 64'(mf));
`endif
  endtask

  initial begin
    logic [63:0] ra, rb, mo;
    logic [3:0]  mf;
    logic [4:0]  roc;
    logic        rc;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.oc        = 5'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c0        = 1'b0;
    #2;
    checkOutput("reset.out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset.o", 64'(bus.o), 64'd0);
`ifdef ALU_FLAGS_EN
    checkOutput("reset.flags", 64'(bus.flags), 64'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset.in_ready", 64'(bus.in_ready), 64'd1);

    // Arithmetic examples
    applyStimulus("add", OC_ADD, 64'd6, 64'd3, 1'b0, 64'd9);
    applyStimulus("neg", OC_NEG, 64'd6, 64'd0, 1'b1, MASK - 64'd5);
    applyStimulus("sub", OC_SUB, 64'd1 << (W - 1), 64'd1, 1'b1, (64'd1 << (W - 1)) - 64'd1);
    applyStimulus("dec", OC_DEC, 64'd6, 64'd0, 1'b0, 64'd5);

    // Shifts and rotates
    applyStimulus("srl1", OC_SRL, 64'h4016, 64'd1, 1'b1, (64'd1 << (W - 1)) | 64'h200B);
    applyStimulus("sll4", OC_SLL, 64'h0016, 64'd4, 1'b0, 64'h0160);
    applyStimulus("ror", OC_ROR, 64'h0001, 64'(W - 1), 1'b0, 64'h0002);
    applyStimulus("sll0", OC_SLL, 64'h1234, 64'd0, 1'b1, 64'h1234);
    applyStimulus("sllmax", OC_SLL, 64'h0005, 64'(W - 1), 1'b0, 64'd1 << (W - 1));
    applyStimulus("rsvd", 5'b11101, 64'h00FF, 64'd3, 1'b1, 64'd0);

    // Backpressure. A waiting request must not be taken while the result is held.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.oc        = OC_OR;
    bus.a         = W'(6);
    bus.b         = W'(3);
    bus.c0        = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.oc = OC_A;
    bus.a  = W'(16'h0055);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp.out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("bp.o", 64'(bus.o), 64'd7);
      checkOutput("bp.in_ready", 64'(bus.in_ready), 64'd0);
    end
    // Release. Two operations are accepted on consecutive edges.
    bus.out_ready = 1'b1;
    bus.oc        = OC_XOR;
    bus.a         = W'(6);
    bus.b         = W'(3);
    @(posedge clk);
    #1;
    bus.oc = OC_ONES;
    @(negedge clk);
    checkOutput("b2b1.out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("b2b1.o", 64'(bus.o), 64'd5);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b2.out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("b2b2.o", 64'(bus.o), MASK);

    // Reset two cycles into an 8-step shift
    @(negedge clk);
    bus.oc       = OC_SLL;
    bus.a        = W'(16'h00F3);
    bus.b        = W'(8);
    bus.c0       = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstmid.out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rstmid.o", 64'(bus.o), 64'd0);
    checkOutput("rstmid.in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("after_rst", OC_AND, 64'd6, 64'd3, 1'b0, 64'd2);

    // Randomized operations against the model
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 3))
        0:       roc = {2'b10, 3'($urandom)};
        1:       roc = {1'b0, 4'($urandom)};
        2:       roc = {3'b110, 2'($urandom)};
        default: roc = 5'($urandom);
      endcase
      ra = {$urandom, $urandom} & MASK;
      rb = {$urandom, $urandom} & MASK;
      rc = 1'($urandom);
      model(roc, ra, rb, rc, mo, mf);
      applyStimulus($sformatf("rnd%0d_oc%05b", i, roc), roc, ra, rb, rc, mo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
